// File: rtl/qam_pkg.sv
// Shared widths and level encoding for the QAM I/Q mixer.
// The level check is the single definition of which I/Q codes the mixer accepts.
package qam_pkg;
  localparam int WAVE_W   = 10;
  localparam int LEVEL_W  = 3;
  localparam int OUT_W    = 13;
  localparam int CNT_W    = 16;
  localparam int WAVE_MID = 512;

  localparam logic [LEVEL_W-1:0] LVL_P3 = 3'b011;
  localparam logic [LEVEL_W-1:0] LVL_P1 = 3'b001;
  localparam logic [LEVEL_W-1:0] LVL_M1 = 3'b111;
  localparam logic [LEVEL_W-1:0] LVL_M3 = 3'b101;

  function automatic logic is_legal_level(input logic [LEVEL_W-1:0] l);
    return (l == LVL_P3) || (l == LVL_P1) || (l == LVL_M1) || (l == LVL_M3);
  endfunction
endpackage

// File: rtl/qam_branch_mult.sv
// One mixer branch: offset-binary carrier to signed (S1), level * carrier product (S2).
module qam_branch_mult
  import qam_pkg::*;
#(
  parameter int WW = qam_pkg::WAVE_W,
  parameter int LW = qam_pkg::LEVEL_W,
  parameter int PW = WW + LW - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LW-1:0] i_lvl,
  input  logic [WW-1:0] i_wave,
  output logic [PW-1:0] o_prod
);
  logic signed [WW-1:0] r_c;
  logic signed [LW-1:0] r_lvl;
  logic signed [PW-1:0] r_prod;
  logic signed [PW-1:0] w_prod;

  // |lvl| <= 3 and |c| <= 512, so the product always fits in PW bits
  assign w_prod = PW'(r_lvl) * PW'(r_c);
  assign o_prod = r_prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c    <= '0;
      r_lvl  <= '0;
      r_prod <= '0;
    end else begin
      r_c    <= i_wave ^ WW'(WAVE_MID);
      r_lvl  <= i_lvl;
      r_prod <= w_prod;
    end
  end
endmodule

// File: rtl/qam_iq_mixer.sv
// QAM I/Q mixer: mod_out = I*cos - Q*sin over a 3-stage pipeline, with strobed
// level capture, sticky illegal-level flag and accepted-symbol counter.
module qam_iq_mixer
  import qam_pkg::*;
#(
  parameter int WAVE_W  = qam_pkg::WAVE_W,
  parameter int LEVEL_W = qam_pkg::LEVEL_W,
  parameter int OUT_W   = qam_pkg::OUT_W,
  parameter int CNT_W   = qam_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sym_stb,
  input  logic               err_clr,
  input  logic [LEVEL_W-1:0] Siga,
  input  logic [LEVEL_W-1:0] Sigb,
  input  logic [WAVE_W-1:0]  SinWave,
  input  logic [WAVE_W-1:0]  CosWave,
  output logic [OUT_W-1:0]   mod_out,
  output logic [OUT_W-1:0]   mod_dac,
  output logic               out_valid,
  output logic               level_err,
  output logic [CNT_W-1:0]   sym_cnt
);
  localparam int PW = WAVE_W + LEVEL_W - 1;

  logic [LEVEL_W-1:0]      r_lvl_a, r_lvl_b;
  logic                    r_err;
  logic [CNT_W-1:0]        r_cnt;
  logic [2:0]              r_vld_pipe;
  logic signed [OUT_W-1:0] r_mod;
  logic                    w_cap, w_ok_a, w_ok_b;
  logic signed [PW-1:0]    w_pa, w_pb;

  assign w_cap  = en & sym_stb;
  assign w_ok_a = is_legal_level(Siga);
  assign w_ok_b = is_legal_level(Sigb);

  qam_branch_mult #(.WW(WAVE_W), .LW(LEVEL_W), .PW(PW)) u_i_branch (
    .clk(clk), .rst(rst), .i_lvl(r_lvl_a), .i_wave(CosWave), .o_prod(w_pa)
  );
  qam_branch_mult #(.WW(WAVE_W), .LW(LEVEL_W), .PW(PW)) u_q_branch (
    .clk(clk), .rst(rst), .i_lvl(r_lvl_b), .i_wave(SinWave), .o_prod(w_pb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lvl_a    <= '0;
      r_lvl_b    <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_vld_pipe <= '0;
      r_mod      <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1:0], en};
      r_mod      <= OUT_W'(w_pa) - OUT_W'(w_pb);
      if (w_cap) begin
        r_lvl_a <= w_ok_a ? Siga : '0;
        r_lvl_b <= w_ok_b ? Sigb : '0;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      // a fresh illegal capture beats a concurrent clear
      if (w_cap && !(w_ok_a && w_ok_b)) r_err <= 1'b1;
      else if (err_clr)                 r_err <= 1'b0;
    end
  end

  assign mod_out   = r_mod;
  assign mod_dac   = {~r_mod[OUT_W-1], r_mod[OUT_W-2:0]};
  assign out_valid = r_vld_pipe[2];
  assign level_err = r_err;
  assign sym_cnt   = r_cnt;
endmodule

// File: tb/tb_qam_iq_mixer.sv
// Randomized self-checking bench for qam_iq_mixer against an arithmetic model.
module tb_qam_iq_mixer;
  logic        clk = 1'b0;
  logic        rst, en, sym_stb, err_clr;
  logic [2:0]  Siga, Sigb;
  logic [9:0]  SinWave, CosWave;
  logic [12:0] mod_out, mod_dac;
  logic        out_valid, level_err;
  logic [15:0] sym_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  int m_la, m_lb, m_cnt;
  bit m_err;
  int hist_mod[$];
  bit hist_v[$];
  int exp_mod;
  bit exp_v;

  qam_iq_mixer dut (
    .clk(clk), .rst(rst), .en(en), .sym_stb(sym_stb), .err_clr(err_clr),
    .Siga(Siga), .Sigb(Sigb), .SinWave(SinWave), .CosWave(CosWave),
    .mod_out(mod_out), .mod_dac(mod_dac), .out_valid(out_valid),
    .level_err(level_err), .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  function automatic int lvl_val(input logic [2:0] c);
    int v;
    v = int'($signed(c));
    if (v == 3 || v == 1 || v == -1 || v == -3) return v;
    return 0;
  endfunction

  task automatic model_reset();
    m_la = 0; m_lb = 0; m_cnt = 0; m_err = 0;
    hist_mod = {0, 0};
    hist_v   = {1'b0, 1'b0};
    exp_mod = 0; exp_v = 0;
  endtask

  // Drive one cycle, advance the model across the edge, return 1ns after the edge.
  task automatic tick(input bit e, input bit s, input bit c, input logic [2:0] a,
                      input logic [2:0] b, input logic [9:0] sn, input logic [9:0] cs);
    bit bad;
    en = e; sym_stb = s; err_clr = c; Siga = a; Sigb = b; SinWave = sn; CosWave = cs;
    @(posedge clk);
    hist_mod.push_back(m_la * (int'(cs) - 512) - m_lb * (int'(sn) - 512));
    hist_v.push_back(e);
    if (e && s) begin
      bad   = (lvl_val(a) == 0) || (lvl_val(b) == 0);
      m_la  = lvl_val(a);
      m_lb  = lvl_val(b);
      m_cnt = (m_cnt + 1) % 65536;
      if (bad) m_err = 1;
      else if (c) m_err = 0;
    end else if (c) begin
      m_err = 0;
    end
    exp_mod = hist_mod.pop_front();
    exp_v   = hist_v.pop_front();
    #1;
  endtask

  task automatic test_reset();
    rst = 0; en = 0; sym_stb = 0; err_clr = 0; Siga = 0; Sigb = 0; SinWave = 0; CosWave = 0;
    #3;
    checks++; if (mod_out !== 13'd0) begin errors++; $display("FAIL reset_mod got %0h exp 0", mod_out); end
    checks++; if (mod_dac !== 13'h1000) begin errors++; $display("FAIL reset_dac got %0h exp 1000", mod_dac); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (level_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", level_err); end
    checks++; if (sym_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", sym_cnt); end
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_basic();
    tick(1, 1, 0, 3'b011, 3'b001, 10'h200, 10'h200);
    repeat (3) tick(1, 0, 0, 3'b000, 3'b000, 10'h200, 10'h3FF);
    checks++; if (mod_out !== 13'd1533) begin errors++; $display("FAIL basic_mod got %0d exp 1533", mod_out); end
    checks++; if (mod_dac !== 13'd5629) begin errors++; $display("FAIL basic_dac got %0d exp 5629", mod_dac); end
    checks++; if (sym_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", sym_cnt); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
  endtask

  task automatic test_extremes();
    tick(1, 1, 0, 3'b101, 3'b011, 10'h000, 10'h000);
    repeat (3) tick(1, 0, 0, 3'b000, 3'b000, 10'h000, 10'h000);
    checks++; if (mod_out !== 13'd3072) begin errors++; $display("FAIL ext_pos got %0d exp 3072", mod_out); end
    tick(1, 1, 0, 3'b011, 3'b101, 10'h000, 10'h000);
    repeat (3) tick(1, 0, 0, 3'b000, 3'b000, 10'h000, 10'h000);
    checks++; if (mod_out !== 13'h1400) begin errors++; $display("FAIL ext_neg got %0h exp 1400", mod_out); end
    checks++; if (mod_dac !== 13'h0400) begin errors++; $display("FAIL ext_neg_dac got %0h exp 0400", mod_dac); end
  endtask

  task automatic test_illegal();
    tick(1, 1, 0, 3'b000, 3'b001, 10'h3FF, 10'h200);
    checks++; if (level_err !== 1'b1) begin errors++; $display("FAIL ill_set got %b exp 1", level_err); end
    repeat (3) tick(1, 0, 0, 3'b000, 3'b000, 10'h3FF, 10'h123);
    checks++; if (mod_out !== 13'h1E01) begin errors++; $display("FAIL ill_mod got %0h exp 1E01 (-511)", mod_out); end
    checks++; if (level_err !== 1'b1) begin errors++; $display("FAIL ill_sticky got %b exp 1", level_err); end
    tick(1, 0, 1, 3'b000, 3'b000, 10'h3FF, 10'h200);
    checks++; if (level_err !== 1'b0) begin errors++; $display("FAIL ill_clr got %b exp 0", level_err); end
    tick(1, 1, 1, 3'b011, 3'b100, 10'h3FF, 10'h200);
    checks++; if (level_err !== 1'b1) begin errors++; $display("FAIL ill_set_wins got %b exp 1", level_err); end
    checks++; if (level_err !== m_err) begin errors++; $display("FAIL ill_model got %b exp %b", level_err, m_err); end
  endtask

  task automatic test_enable_gap();
    int saved_cnt, lows, first_low;
    repeat (4) tick(1, 0, 0, 3'b001, 3'b001, 10'($urandom), 10'($urandom));
    saved_cnt = m_cnt; lows = 0; first_low = -1;
    for (int k = 1; k <= 13; k++) begin
      if (k <= 5) tick(0, 1, 0, 3'b011, 3'b111, 10'($urandom), 10'($urandom));
      else        tick(1, 0, 0, 3'b000, 3'b000, 10'($urandom), 10'($urandom));
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL gap_valid k=%0d got %b exp %b", k, out_valid, exp_v); end
      checks++; if (mod_out !== 13'(exp_mod)) begin errors++; $display("FAIL gap_mod k=%0d got %0d exp %0d", k, $signed(mod_out), exp_mod); end
      if (out_valid === 1'b0) begin lows++; if (first_low < 0) first_low = k; end
    end
    checks++; if (lows != 5) begin errors++; $display("FAIL gap_len got %0d exp 5", lows); end
    checks++; if (first_low != 3) begin errors++; $display("FAIL gap_start got %0d exp 3", first_low); end
    checks++; if (sym_cnt !== 16'(saved_cnt)) begin errors++; $display("FAIL gap_cnt got %0d exp %0d", sym_cnt, saved_cnt); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 300; t++) begin
      tick($urandom_range(0, 7) != 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
           3'($urandom), 3'($urandom), 10'($urandom), 10'($urandom));
      checks++; if (mod_out !== 13'(exp_mod)) begin errors++; $display("FAIL rand_mod t=%0d got %0d exp %0d", t, $signed(mod_out), exp_mod); end
      checks++; if (mod_dac !== 13'(exp_mod + 4096)) begin errors++; $display("FAIL rand_dac t=%0d got %0d exp %0d", t, mod_dac, exp_mod + 4096); end
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rand_valid t=%0d got %b exp %b", t, out_valid, exp_v); end
      checks++; if (level_err !== m_err) begin errors++; $display("FAIL rand_err t=%0d got %b exp %b", t, level_err, m_err); end
      checks++; if (sym_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rand_cnt t=%0d got %0d exp %0d", t, sym_cnt, m_cnt); end
    end
  endtask

  task automatic test_async_reset();
    tick(1, 1, 0, 3'b011, 3'b101, 10'h155, 10'h2AA);
    repeat (4) tick(1, 0, 0, 3'b000, 3'b000, 10'($urandom), 10'($urandom));
    #2 rst = 0;
    #1;
    checks++; if (mod_out !== 13'd0) begin errors++; $display("FAIL arst_mod got %0h exp 0", mod_out); end
    checks++; if (mod_dac !== 13'h1000) begin errors++; $display("FAIL arst_dac got %0h exp 1000", mod_dac); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", out_valid); end
    checks++; if (sym_cnt !== 16'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", sym_cnt); end
    checks++; if (level_err !== 1'b0) begin errors++; $display("FAIL arst_err got %b exp 0", level_err); end
    model_reset();
    @(negedge clk);
    rst = 1;
    for (int k = 1; k <= 4; k++) begin
      tick(1, 0, 0, 3'b000, 3'b000, 10'h3FF, 10'h000);
      checks++; if (out_valid !== (k >= 3)) begin errors++; $display("FAIL arst_valid_ret k=%0d got %b exp %b", k, out_valid, k >= 3); end
      checks++; if (mod_out !== 13'(exp_mod)) begin errors++; $display("FAIL arst_mod_ret k=%0d got %0d exp %0d", k, $signed(mod_out), exp_mod); end
    end
  endtask

  task automatic test_wrap();
    #2 rst = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 65535; i++) tick(1, 1, 0, 3'b001, 3'b111, 10'h200, 10'h200);
    checks++; if (sym_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got %0h exp FFFF", sym_cnt); end
    tick(1, 1, 0, 3'b001, 3'b111, 10'h200, 10'h200);
    checks++; if (sym_cnt !== 16'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", sym_cnt); end
    checks++; if (level_err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", level_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_illegal();
    test_enable_gap();
    test_random();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
